// File: rtl/iitb_mem_pkg.sv
// Shared types for the IITB-RISC memory stage: FSM states, LM/SM mask and
// register-index types.
package iitb_mem_pkg;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned RIDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [RIDX_W-1:0] ridx_t;

  function automatic mask_t ridx_onehot(input ridx_t r);
    return mask_t'(1) << r;
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_access_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/lmsm_mask_scan.sv
// Lowest-set-bit encoder for the LM/SM register mask: returns the index of
// the next register to transfer and whether any bit remains.
module lmsm_mask_scan
  import iitb_mem_pkg::*;
(
  input  mask_t mask,
  output ridx_t idx,
  output logic  any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (mask[i] && !any) begin
        idx = ridx_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// IITB-RISC memory stage: load/store handshake, LM/SM sequencing and the
// MEM/WB register. LM/SM multi-transfer support is built when MEM_LMSM_EN is defined.
module mem_stage_access
  import iitb_mem_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_mem,
  input  logic [DW-1:0]        alu_result_mem,
  input  logic [DW-1:0]        reg2data_mem,
  input  logic [2:0]           regdst_mem,
  input  logic                 regwrite_mem,
  input  logic                 memtoreg_mem,
  input  logic                 memread_mem,
  input  logic                 memwrite_mem,
  input  logic                 lm_mem,
  input  logic                 sm_mem,
  input  logic [DW-1:0]        imm9_0_pad_mem,
  output logic                 stall,
  mem_stage_access_if.master   dmem,
  output logic [2:0]           sm_rd_addr,
  input  logic [DW-1:0]        sm_rd_data,
  output logic                 wb_valid,
  output logic                 wb_regwrite,
  output logic [2:0]           wb_regdst,
  output logic [DW-1:0]        wb_data
);

  state_t state_q;
  logic   is_mem;
  logic   is_lmsm;
  logic   acc_go;
  logic   multi_go;

  assign is_mem  = memread_mem || memwrite_mem;
  assign is_lmsm = lm_mem || sm_mem;
  // LM/SM takes priority over the plain memread/memwrite decode.
  assign acc_go  = valid_mem && is_mem && !is_lmsm;

`ifdef MEM_LMSM_EN
  mask_t          mask_q;
  mask_t          mask_in;
  mask_t          mask_next;
  logic [AW-1:0]  addr_q;
  logic           sm_q;
  ridx_t          beat_idx;
  logic           beat_any;
  logic           beat_last;
  logic           unused_imm;

  assign mask_in    = imm9_0_pad_mem[MASK_W-1:0];
  assign multi_go   = valid_mem && is_lmsm && (mask_in != '0);
  assign mask_next  = mask_q & ~ridx_onehot(beat_idx);
  assign beat_last  = (mask_next == '0);
  assign unused_imm = ^imm9_0_pad_mem[DW-1:MASK_W];

  lmsm_mask_scan u_scan (
    .mask (mask_q),
    .idx  (beat_idx),
    .any  (beat_any)
  );
`else
  logic unused_cfg;

  assign multi_go   = 1'b0;
  assign sm_rd_addr = '0;
  assign unused_cfg = ^{imm9_0_pad_mem, sm_rd_data};
`endif

  always_comb begin
    stall           = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
`ifdef MEM_LMSM_EN
    sm_rd_addr      = '0;
`endif
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (multi_go) begin
            stall = 1'b1;
          end else if (acc_go) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = memwrite_mem;
            dmem.dmem_addr  = AW'(alu_result_mem);
            dmem.dmem_wdata = reg2data_mem;
            stall           = !dmem.dmem_ack;
          end
        end
`ifdef MEM_LMSM_EN
        MULTI: begin
          if (beat_any) begin
            dmem.dmem_req  = 1'b1;
            dmem.dmem_we   = sm_q;
            dmem.dmem_addr = addr_q;
            if (sm_q) begin
              sm_rd_addr      = beat_idx;
              dmem.dmem_wdata = sm_rd_data;
            end
            // The beat that retires the final mask bit releases EX/MEM.
            stall = !(dmem.dmem_ack && beat_last);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_regdst   <= '0;
      wb_data     <= '0;
`ifdef MEM_LMSM_EN
      mask_q      <= '0;
      addr_q      <= '0;
      sm_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!valid_mem) begin
            wb_valid <= 1'b0;
`ifdef MEM_LMSM_EN
          end else if (multi_go) begin
            mask_q   <= mask_in;
            addr_q   <= AW'(alu_result_mem);
            sm_q     <= sm_mem;
            wb_valid <= 1'b0;
            state_q  <= MULTI;
`endif
          end else if (is_lmsm) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_regdst   <= regdst_mem;
            wb_data     <= alu_result_mem;
          end else if (is_mem) begin
            if (dmem.dmem_ack) begin
              wb_valid    <= 1'b1;
              wb_regwrite <= regwrite_mem;
              wb_regdst   <= regdst_mem;
              wb_data     <= memtoreg_mem ? dmem.dmem_rdata : alu_result_mem;
            end else begin
              wb_valid <= 1'b0;
            end
          end else begin
            wb_valid    <= 1'b1;
            wb_regwrite <= regwrite_mem;
            wb_regdst   <= regdst_mem;
            wb_data     <= alu_result_mem;
          end
        end
`ifdef MEM_LMSM_EN
        MULTI: begin
          if (dmem.dmem_ack && beat_any) begin
            mask_q      <= mask_next;
            addr_q      <= addr_q + AW'(1);
            wb_valid    <= 1'b1;
            wb_regwrite <= !sm_q;
            wb_regdst   <= beat_idx;
            if (!sm_q) begin
              wb_data <= dmem.dmem_rdata;
            end
            if (beat_last) begin
              state_q <= IDLE;
            end
          end else begin
            wb_valid <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: memory responder with programmable
// wait states, write-back scoreboard and per-scenario checks.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem;
  logic [15:0] alu_result_mem;
  logic [15:0] reg2data_mem;
  logic [2:0]  regdst_mem;
  logic        regwrite_mem, memtoreg_mem, memread_mem, memwrite_mem;
  logic        lm_mem, sm_mem;
  logic [15:0] imm9_0_pad_mem;
  logic        stall;
  logic [2:0]  sm_rd_addr;
  logic [15:0] sm_rd_data;
  logic        wb_valid, wb_regwrite;
  logic [2:0]  wb_regdst;
  logic [15:0] wb_data;

  mem_stage_access_if #(.AW(16), .DW(16)) dmem_if ();

  mem_stage_access #(.AW(16), .DW(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_mem      (valid_mem),
    .alu_result_mem (alu_result_mem),
    .reg2data_mem   (reg2data_mem),
    .regdst_mem     (regdst_mem),
    .regwrite_mem   (regwrite_mem),
    .memtoreg_mem   (memtoreg_mem),
    .memread_mem    (memread_mem),
    .memwrite_mem   (memwrite_mem),
    .lm_mem         (lm_mem),
    .sm_mem         (sm_mem),
    .imm9_0_pad_mem (imm9_0_pad_mem),
    .stall          (stall),
    .dmem           (dmem_if),
    .sm_rd_addr     (sm_rd_addr),
    .sm_rd_data     (sm_rd_data),
    .wb_valid       (wb_valid),
    .wb_regwrite    (wb_regwrite),
    .wb_regdst      (wb_regdst),
    .wb_data        (wb_data)
  );

  always #5 clk = ~clk;

  // Memory model: ack after wait_target stall cycles; read data is address-derived.
  int unsigned wait_target = 0;
  int unsigned wait_cnt;
  logic        force_ack = 1'b0;

  assign dmem_if.dmem_ack   = (dmem_if.dmem_req && (wait_cnt >= wait_target)) || force_ack;
  assign dmem_if.dmem_rdata = (dmem_if.dmem_addr == 16'h0040) ? 16'hBEEF
                                                              : (dmem_if.dmem_addr ^ 16'h5A5A);
  assign sm_rd_data = 16'hC000 | {13'd0, sm_rd_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (dmem_if.dmem_req && !dmem_if.dmem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  logic [31:0] wr_q[$];
  always @(posedge clk) begin
    if (rst_n === 1'b1 && dmem_if.dmem_req && dmem_if.dmem_ack && dmem_if.dmem_we)
      wr_q.push_back({dmem_if.dmem_addr, dmem_if.dmem_wdata});
  end

  typedef struct {
    logic [2:0]  dst;
    logic        regwrite;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: every write-back beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_unexpected: got wb_valid=1 dst=%0d data=%h, required no write-back",
                 wb_regdst, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_regwrite !== mon_e.regwrite ||
            (mon_e.chk_data && (wb_regdst !== mon_e.dst || wb_data !== mon_e.data))) begin
          tests_failed++;
          $display("FAIL wb_beat: got rw=%b dst=%0d data=%h, required rw=%b dst=%0d data=%h",
                   wb_regwrite, wb_regdst, wb_data, mon_e.regwrite, mon_e.dst, mon_e.data);
        end
      end
    end
  end

  task automatic set_idle();
    valid_mem = 0; alu_result_mem = '0; reg2data_mem = '0; regdst_mem = '0;
    regwrite_mem = 0; memtoreg_mem = 0; memread_mem = 0; memwrite_mem = 0;
    lm_mem = 0; sm_mem = 0; imm9_0_pad_mem = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic lm, input logic sm, input logic [2:0] dst,
                       input logic [15:0] alu, input logic [15:0] r2, input logic [15:0] imm);
    valid_mem = 1; memread_mem = rd; memwrite_mem = wr; memtoreg_mem = m2r;
    regwrite_mem = rw; lm_mem = lm; sm_mem = sm; regdst_mem = dst;
    alu_result_mem = alu; reg2data_mem = r2; imm9_0_pad_mem = imm;
  endtask

  function automatic exp_t mk(input logic [2:0] d, input logic rw, input logic chk,
                              input logic [15:0] v);
    exp_t e;
    e.dst = d; e.regwrite = rw; e.chk_data = chk; e.data = v;
    return e;
  endfunction

  // Steps the held instruction until stall drops, counting stall/req/we cycles.
  task automatic run_until_free(output int stall_n, output int req_n, output int we_n,
                                output bit timeout);
    stall_n = 0; req_n = 0; we_n = 0; timeout = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall === 1'b1) stall_n++;
      if (dmem_if.dmem_req === 1'b1) req_n++;
      if (dmem_if.dmem_we === 1'b1) we_n++;
      @(posedge clk);
      if (stall === 1'b0) begin
        timeout = 0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    set_idle();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d write-backs missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    repeat (2) @(negedge clk);
    drive(1, 0, 1, 1, 0, 0, 3'd1, 16'h0040, 16'h0, 16'h0);
    #1;
    tests_run++;
    if ({wb_valid, wb_regwrite, wb_regdst, wb_data} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_wb: got v=%b rw=%b dst=%0d data=%h, required all 0",
               wb_valid, wb_regwrite, wb_regdst, wb_data);
    end
    tests_run++;
    if ({stall, dmem_if.dmem_req, dmem_if.dmem_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b, required 000",
               stall, dmem_if.dmem_req, dmem_if.dmem_we);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    int s, r, w; bit to;
    drive(0, 0, 0, 1, 0, 0, 3'd3, 16'h1234, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd3, 1, 1, 16'h1234));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 0 || r != 0) begin
      tests_failed++;
      $display("FAIL alu_stall: got stall=%0d req=%0d timeout=%0b, required 0 0 0", s, r, to);
    end
    drain("alu");
  endtask

  task automatic test_load_wait();
    int s, r, w; bit to;
    wait_target = 2;
    drive(1, 0, 1, 1, 0, 0, 3'd5, 16'h0040, 16'h0, 16'h0);
    #1;
    tests_run++;
    if (dmem_if.dmem_addr !== 16'h0040 || dmem_if.dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_addr: got req=%b addr=%h, required 1 0040",
               dmem_if.dmem_req, dmem_if.dmem_addr);
    end
    exp_q.push_back(mk(3'd5, 1, 1, 16'hBEEF));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 2 || r != 3 || w != 0) begin
      tests_failed++;
      $display("FAIL load_wait: got stall=%0d req=%0d we=%0d to=%0b, required 2 3 0 0",
               s, r, w, to);
    end
    wait_target = 0;
    drain("load");
  endtask

  task automatic test_back_to_back();
    int s, r, w; bit to;
    int stall_seen = 0;
    logic [31:0] got;
    wr_q.delete();
    drive(0, 1, 0, 0, 0, 0, 3'd0, 16'h0300, 16'h1111, 16'h0);
    exp_q.push_back(mk(3'd0, 0, 0, 16'h0));
    run_until_free(s, r, w, to); stall_seen += s + int'(to);
    drive(1, 0, 1, 1, 0, 0, 3'd4, 16'h0301, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd4, 1, 1, 16'h595B));
    run_until_free(s, r, w, to); stall_seen += s + int'(to);
    drive(0, 0, 0, 1, 0, 0, 3'd6, 16'h4242, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd6, 1, 1, 16'h4242));
    run_until_free(s, r, w, to); stall_seen += s + int'(to);
    tests_run++;
    if (stall_seen != 0) begin
      tests_failed++;
      $display("FAIL b2b_stall: got %0d stall cycles, required 0", stall_seen);
    end
    drain("b2b");
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hXXXX_XXXX;
    tests_run++;
    if (got !== 32'h0300_1111 || wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_store: got %h (+%0d more), required 03001111", got, wr_q.size());
    end
  endtask

  task automatic test_ack_without_req();
    force_ack = 1;
    set_idle();
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 3'd2, 16'h7777, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd2, 1, 1, 16'h7777));
    @(negedge clk);
    force_ack = 0;
    drain("stray_ack");
  endtask

  task automatic test_lmsm_zero_mask();
    int s, r, w; bit to;
    drive(0, 0, 0, 1, 1, 0, 3'd1, 16'h0500, 16'h0, 16'h0000);
    exp_q.push_back(mk(3'd0, 0, 0, 16'h0));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 0 || r != 0) begin
      tests_failed++;
      $display("FAIL lm_mask0: got stall=%0d req=%0d to=%0b, required 0 0 0", s, r, to);
    end
    drain("lm_mask0");
  endtask

  task automatic test_reset_mid_access();
    wait_target = 5;
    drive(1, 0, 1, 1, 0, 0, 3'd1, 16'h0080, 16'h0, 16'h0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests_run++;
    if ({stall, dmem_if.dmem_req, wb_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_access: got stall=%b req=%b wb_valid=%b, required 000",
               stall, dmem_if.dmem_req, wb_valid);
    end
    set_idle();
    wait_target = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 3'd7, 16'h0A0A, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd7, 1, 1, 16'h0A0A));
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_access_next: got stall=%b, required 0", stall);
    end
    @(negedge clk);
    drain("rst_access");
  endtask

`ifdef MEM_LMSM_EN
  task automatic test_sm();
    int s, r, w; bit to;
    logic [31:0] a, b;
    wr_q.delete();
    drive(0, 0, 0, 0, 0, 1, 3'd0, 16'h0100, 16'h0, 16'h0005);
    exp_q.push_back(mk(3'd0, 0, 0, 16'h0));
    exp_q.push_back(mk(3'd2, 0, 0, 16'h0));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 2 || r != 2 || w != 2) begin
      tests_failed++;
      $display("FAIL sm_cycles: got stall=%0d req=%0d we=%0d to=%0b, required 2 2 2 0",
               s, r, w, to);
    end
    drain("sm");
    a = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hXXXX_XXXX;
    b = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hXXXX_XXXX;
    tests_run++;
    if (a !== 32'h0100_C000 || b !== 32'h0101_C002) begin
      tests_failed++;
      $display("FAIL sm_writes: got %h %h, required 0100c000 0101c002", a, b);
    end
  endtask

  task automatic test_lm_wrap();
    int s, r, w; bit to;
    drive(0, 0, 0, 1, 1, 0, 3'd0, 16'hFFFF, 16'h0, 16'h0081);
    exp_q.push_back(mk(3'd0, 1, 1, 16'hA5A5));
    exp_q.push_back(mk(3'd7, 1, 1, 16'h5A5A));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 2 || r != 2 || w != 0) begin
      tests_failed++;
      $display("FAIL lm_cycles: got stall=%0d req=%0d we=%0d to=%0b, required 2 2 0 0",
               s, r, w, to);
    end
    drain("lm_wrap");
  endtask

  task automatic test_reset_mid_multi();
    drive(0, 0, 0, 1, 1, 0, 3'd0, 16'h0200, 16'h0, 16'h0007);
    exp_q.push_back(mk(3'd0, 1, 1, 16'h585A));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests_run++;
    if ({stall, dmem_if.dmem_req, wb_valid, wb_regwrite} !== 4'b0000 || wb_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_multi: got stall=%b req=%b v=%b rw=%b data=%h, required 0000 0000",
               stall, dmem_if.dmem_req, wb_valid, wb_regwrite, wb_data);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 3'd1, 16'h00AB, 16'h0, 16'h0);
    exp_q.push_back(mk(3'd1, 1, 1, 16'h00AB));
    #1;
    tests_run++;
    if (stall !== 1'b0 || dmem_if.dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_multi_next: got stall=%b req=%b, required 0 0",
               stall, dmem_if.dmem_req);
    end
    @(negedge clk);
    drain("rst_multi");
  endtask
`else
  task automatic test_lmsm_disabled();
    int s, r, w; bit to;
    drive(0, 0, 0, 1, 1, 0, 3'd0, 16'hFFFF, 16'h0, 16'h0081);
    exp_q.push_back(mk(3'd0, 0, 0, 16'h0));
    run_until_free(s, r, w, to);
    tests_run++;
    if (to || s != 0 || r != 0 || sm_rd_addr !== 3'd0) begin
      tests_failed++;
      $display("FAIL lmsm_off: got stall=%0d req=%0d sm_rd_addr=%0d to=%0b, required 0 0 0 0",
               s, r, sm_rd_addr, to);
    end
    drain("lmsm_off");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_ack_without_req();
    test_lmsm_zero_mask();
    test_reset_mid_access();
`ifdef MEM_LMSM_EN
    test_sm();
    test_lm_wrap();
    test_reset_mid_multi();
`else
    test_lmsm_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

Memory-stage access unit of the IITB-RISC pipeline: consumes the EX/MEM bundle, performs the data-memory load/store through a ready/acknowledge handshake, and sequences LM/SM multi-register transfers from the 8-bit register mask. It contains the MEM/WB register, so its outputs are the registered write-back bundle. It drives `stall` back to IF–EX so the EX/MEM bundle is held while an access or an LM/SM sequence is in flight.

## Interface
- `AW`, 16, data-memory address width
- `DW`, 16, data width
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `valid_mem` in 1 — EX/MEM bundle valid (0 = bubble)
- `alu_result_mem` in DW — address for load/store/LM/SM; ALU result otherwise
- `reg2data_mem` in DW — store data
- `regdst_mem` in 3 — destination register
- `regwrite_mem`, `memtoreg_mem`, `memread_mem`, `memwrite_mem` in 1 each — control
- `lm_mem`, `sm_mem` in 1 each — LM / SM instruction
- `imm9_0_pad_mem` in DW — bits [7:0] = LM/SM register mask, bit i = Ri
- `stall` out 1 — hold IF..EX/MEM this cycle
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out AW, `dmem_wdata` out DW
- `dmem_ack` in 1 — access completes this cycle; `dmem_rdata` in DW valid with ack
- `sm_rd_addr` out 3, `sm_rd_data` in DW — combinational register-file read for SM
- `wb_valid`, `wb_regwrite` out 1 each, `wb_regdst` out 3, `wb_data` out DW — MEM/WB bundle

## Operation
- States: IDLE, MULTI.
- IDLE, `valid_mem`=0: wb_valid←0 at edge.
- IDLE, no memory op: wb_data←alu_result_mem, wb_regdst, wb_regwrite registered, wb_valid←1.
- IDLE, memread/memwrite: dmem_req=1, dmem_addr=alu_result_mem, dmem_we=memwrite_mem, dmem_wdata=reg2data_mem, all combinational from inputs. stall = !dmem_ack. On ack edge: wb registered; wb_data = memtoreg ? dmem_rdata : alu_result_mem.
- IDLE, lm/sm with mask≠0: stall=1; at edge latch addr←alu_result_mem, mask←imm[7:0], → MULTI; wb_valid←0.
- lm/sm with mask=0: no access; bubble (wb_valid←1, wb_regwrite←0).
- MULTI: r = lowest set bit of mask. dmem_req=1, dmem_addr=addr, dmem_we=sm. SM: sm_rd_addr=r, dmem_wdata=sm_rd_data. On ack: clear bit r, addr←addr+1 (mod 2^AW); LM: wb_valid←1, wb_regwrite←1, wb_regdst←r, wb_data←dmem_rdata; SM: wb_valid←1, wb_regwrite←0. No ack: wb_valid←0.
- stall=1 throughout MULTI except the cycle where ack clears the last bit (stall=0; EX/MEM advances at that edge; → IDLE).
- dmem_req never asserted without a valid access; dmem_we=0 whenever dmem_req=0.

## Timing
- Reset (async, any state incl. mid-MULTI or mid-access): state IDLE, mask 0, addr 0, wb_valid/wb_regwrite 0, wb_regdst 0, wb_data 0; dmem_req/stall/dmem_we 0 while rst_n=0; abandoned access not retried.
- Zero-wait memory (ack same cycle as req): single access costs 1 cycle, no stall; LM/SM with n set bits costs n+1 cycles (1 entry + n beats), stall asserted n cycles.
- Write-back latency: 1 edge after completing cycle.
- Ack without req: ignored.
- Address wrap 0xFFFF→0x0000 silently.

## Configuration
- `MEM_LMSM_EN` defined: MULTI state, mask scan and sm_rd_addr logic present.
- Undefined: lm/sm treated as mask=0 bubbles (no access, no stall); sm_rd_addr tied 0; FSM reduces to IDLE.

## Structure
- Package `iitb_mem_pkg`: state enum (IDLE, MULTI), `NREGS`=8, mask width 8, register-index width 3.
- Sub-module `lmsm_mask_scan`: combinational lowest-set-bit encoder (8-bit mask → 3-bit index + any-set flag).

## Test plan
- ALU op, valid, alu_result=0x1234, regdst=3, regwrite=1 -> next edge wb_valid=1, wb_data=0x1234, wb_regdst=3, stall never high.
- Load addr 0x0040, ack after 2 wait cycles, rdata=0xBEEF -> stall high 2 cycles, dmem_we=0, wb_data=0xBEEF one edge after ack.
- SM base 0x0100 mask 0x05, zero-wait -> writes (0x0100,R0),(0x0101,R2) via sm_rd_addr 0 then 2; stall 2 cycles; wb_regwrite=0.
- LM base 0xFFFF mask 0x81, zero-wait -> reads 0xFFFF→R0, 0x0000→R7; wb_regdst 0 then 7.
- LM mask 0x00 -> no dmem_req, no stall, one bubble.
- rst_n low mid-MULTI after one beat -> dmem_req/stall drop immediately, wb_valid=0; next instruction runs from IDLE.
